sram_responder: RTL and testbench

- Synthesizable responder for the 64-bit SRAM bus driven by the MEM stage's SRAM controller.
- Serves as the device end of that bus for simulation and FPGA bring-up without external SRAM.
- Decodes the SRAM control strobes and stores data in an internal array with configurable access latency.
- Drives SRAM_DQ only during qualified read windows.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_responder_array.sv | 43 ++++
 rtl/sram_responder.sv | 150 +++++++++++++++
 tb/tb_sram_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM responder: FSM state, latched
// operation kind, bus geometry and the byte-lane split point.
package sram_pkg;

    localparam int SRAM_ADDR_W     = 17;
    localparam int SRAM_DATA_W     = 64;
    localparam int SRAM_LANE_SPLIT = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HOLD
    } state_t;

    typedef enum logic {
        OP_WRITE,
        OP_READ
    } op_t;

    // Index width for the storage array; never below one bit so a
    // single-word array still has a legal index port.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_responder_array.sv
// Storage for the SRAM responder: DEPTH words split into two independent
// 32-bit lanes so each half can be written alone, with a registered read
// port. Every lane is a plain array with a synchronous write and a
// synchronous read, which maps onto block RAM.
module sram_responder_array
    import sram_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = 10,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic [1:0]        i_wr_lane,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [DATA_W-1:0] o_rd_data
);

    localparam int LANE_W = SRAM_LANE_SPLIT;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [LANE_W-1:0] r_mem [DEPTH];
            logic [LANE_W-1:0] r_rd;

            // Lane write and registered lane read; the controller never
            // requests both on the same edge.
            always_ff @(posedge clk) begin
                if (i_wr_lane[gi]) begin
                    r_mem[i_idx] <= i_wr_data[gi*LANE_W +: LANE_W];
                end
                if (i_rd_en) begin
                    r_rd <= r_mem[i_idx];
                end
            end

            assign o_rd_data[gi*LANE_W +: LANE_W] = r_rd;
        end
    endgenerate

endmodule

// File: rtl/sram_responder.sv
// Device end of the 64-bit SRAM bus: decodes CE_N/WE_N/OE_N, waits a fixed
// ACCESS_CYCLES latency, commits writes per byte lane or loads read data,
// and drives SRAM_DQ only while a read result is held and OE_N/CE_N are low.
// Optional macro SRAM_RESP_ERR_EN adds a sticky out-of-range flag
// (addr_err) with a synchronous clear input (err_clr).
module sram_responder
    import sram_pkg::*;
#(
    parameter int ADDR_W        = SRAM_ADDR_W,
    parameter int DATA_W        = SRAM_DATA_W,
    parameter int MEM_DEPTH     = 1024,
    parameter int ACCESS_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_OE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              busy,
    output logic              rd_valid
`ifdef SRAM_RESP_ERR_EN
    ,
    output logic              addr_err,
    input  logic              err_clr
`endif
);

    localparam int         IDX_W    = idx_width(MEM_DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

    state_t             r_state;
    op_t                r_op;
    logic [3:0]         r_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_in_range;
    logic [1:0]         r_lanes;     // {upper, lower} write enables, active high
    logic               r_rd_zero;   // held read came from an out-of-range address
    logic               r_busy;

    logic               w_in_range;
    logic               w_capture;
    logic               w_commit;
    logic [1:0]         w_wr_lane;
    logic               w_rd_en;
    logic               w_drive;
    logic [DATA_W-1:0]  w_array_q;
    logic [DATA_W-1:0]  w_rd_data;

    // Range check on the full address; the array index is taken from the
    // low bits only when this passes, so high addresses never alias.
    assign w_in_range = (32'(SRAM_ADDR) < 32'(MEM_DEPTH));
    assign w_capture  = (r_state == IDLE) && !SRAM_CE_N && (!SRAM_WE_N || !SRAM_OE_N);
    assign w_commit   = (r_state == ACCESS) && !SRAM_CE_N && (r_cnt == 4'd0);
    assign w_wr_lane  = (w_commit && (r_op == OP_WRITE) && r_in_range) ? r_lanes : 2'b00;
    assign w_rd_en    = w_commit && (r_op == OP_READ) && r_in_range;

    sram_responder_array #(
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk       (clk),
        .i_wr_lane (w_wr_lane),
        .i_idx     (r_idx),
        .i_wr_data (SRAM_DQ),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_array_q)
    );

    // Read drive follows OE_N/CE_N combinationally and drops at once on rst.
    assign w_rd_data = r_rd_zero ? '0 : w_array_q;
    assign w_drive   = !rst && (r_state == HOLD) && (r_op == OP_READ) && !SRAM_CE_N && !SRAM_OE_N;
    assign SRAM_DQ   = w_drive ? w_rd_data : 'z;
    assign rd_valid  = w_drive;
    assign busy      = r_busy;

    // Command FSM: capture in IDLE, count latency in ACCESS, hold the
    // result until the controller releases the strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= OP_READ;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_in_range <= 1'b0;
            r_lanes    <= 2'b00;
            r_rd_zero  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        // Lane enables are latched with the command; only DQ
                        // is sampled at the commit edge.
                        r_op       <= !SRAM_WE_N ? OP_WRITE : OP_READ;
                        r_idx      <= SRAM_ADDR[IDX_W-1:0];
                        r_in_range <= w_in_range;
                        r_lanes    <= {!SRAM_UB_N, !SRAM_LB_N};
                        r_cnt      <= CNT_INIT;
                        r_busy     <= 1'b1;
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (SRAM_CE_N) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == 4'd0) begin
                        r_rd_zero <= !r_in_range;
                        r_busy    <= 1'b0;
                        r_state   <= HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (SRAM_CE_N || (SRAM_WE_N && SRAM_OE_N)) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SRAM_RESP_ERR_EN
    logic r_addr_err;

    // Sticky out-of-range flag; a capture on the same edge as err_clr wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else if (w_capture && !w_in_range) begin
            r_addr_err <= 1'b1;
        end else if (err_clr) begin
            r_addr_err <= 1'b0;
        end
    end

    assign addr_err = r_addr_err;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: table-driven write/read vectors,
// hand-written multi-cycle corner cases, and randomized traffic compared
// against an associative-array memory model.
module tb_sram_responder;

    localparam int ACCESS_CYCLES = 4;
    localparam int MEM_DEPTH     = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] SRAM_ADDR = '0;
    logic        SRAM_WE_N = 1'b1;
    logic        SRAM_OE_N = 1'b1;
    logic        SRAM_CE_N = 1'b1;
    logic        SRAM_UB_N = 1'b1;
    logic        SRAM_LB_N = 1'b1;
    wire  [63:0] SRAM_DQ;
    logic        busy;
    logic        rd_valid;
    logic        tb_drv = 1'b0;
    logic [63:0] tb_dq = '0;
`ifdef SRAM_RESP_ERR_EN
    logic        addr_err;
    logic        err_clr = 1'b0;
`endif

    assign SRAM_DQ = tb_drv ? tb_dq : 'z;

    always #5 clk = ~clk;

    sram_responder #(
        .ADDR_W        (17),
        .DATA_W        (64),
        .MEM_DEPTH     (MEM_DEPTH),
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N),
        .SRAM_CE_N (SRAM_CE_N),
        .SRAM_UB_N (SRAM_UB_N),
        .SRAM_LB_N (SRAM_LB_N),
        .SRAM_DQ   (SRAM_DQ),
        .busy      (busy),
        .rd_valid  (rd_valid)
`ifdef SRAM_RESP_ERR_EN
        ,
        .addr_err  (addr_err),
        .err_clr   (err_clr)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    logic [63:0] model [int];

    typedef struct {
        bit          wr;
        logic [16:0] addr;
        logic [63:0] data;
        bit          ub_n;
        bit          lb_n;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // Undriven bus: Z in a four-state simulator, zero in a two-state one.
    function automatic bit dq_released();
        return (SRAM_DQ === {64{1'bz}}) || (SRAM_DQ === 64'h0);
    endfunction

    task automatic check_released(input string name);
        n_total++;
        if (!dq_released()) $display("FAIL %s: bus got %h expected released", name, SRAM_DQ);
        else n_pass++;
    endtask

    // Behavioural memory: only in-range addresses exist; lanes merge on write.
    function automatic void model_write(input logic [16:0] a, input logic [63:0] d, input bit ub_n, input bit lb_n);
        logic [63:0] m;
        if (int'(a) >= MEM_DEPTH) return;
        m = model.exists(int'(a)) ? model[int'(a)] : 64'h0;
        if (!lb_n) m[31:0]  = d[31:0];
        if (!ub_n) m[63:32] = d[63:32];
        model[int'(a)] = m;
    endfunction

    function automatic logic [63:0] model_read(input logic [16:0] a);
        if (int'(a) >= MEM_DEPTH) return 64'h0;
        return model[int'(a)];
    endfunction

    // From the negedge where a command was set up: count cycles busy stays high.
    task automatic run_access(output int cyc, output bit saw_rdv);
        cyc = 0;
        saw_rdv = 1'b0;
        @(negedge clk);
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            if (rd_valid !== 1'b0) saw_rdv = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [16:0] a, input logic [63:0] d, input bit ub_n, input bit lb_n);
        int cyc;
        bit rdv;
        SRAM_ADDR = a; SRAM_CE_N = 0; SRAM_WE_N = 0; SRAM_OE_N = 1;
        SRAM_UB_N = ub_n; SRAM_LB_N = lb_n; tb_dq = d; tb_drv = 1;
        run_access(cyc, rdv);
        check("wr_busy_cycles", 64'(cyc), 64'(ACCESS_CYCLES));
        check("wr_no_rd_valid", {63'h0, rdv | rd_valid}, 64'h0);
        SRAM_CE_N = 1; SRAM_WE_N = 1; SRAM_UB_N = 1; SRAM_LB_N = 1; tb_drv = 0;
        @(negedge clk);
        model_write(a, d, ub_n, lb_n);
        $display("txn WR addr=%05h data=%016h ub_n=%0b lb_n=%0b busy_cycles=%0d", a, d, ub_n, lb_n, cyc);
    endtask

    task automatic do_read(input logic [16:0] a, input logic [63:0] exp, output logic [63:0] got);
        int cyc;
        bit rdv;
        SRAM_ADDR = a; SRAM_CE_N = 0; SRAM_WE_N = 1; SRAM_OE_N = 0; tb_drv = 0;
        run_access(cyc, rdv);
        check("rd_busy_cycles", 64'(cyc), 64'(ACCESS_CYCLES));
        check("rd_valid_in_access", {63'h0, rdv}, 64'h0);
        check("rd_valid_in_hold", {63'h0, rd_valid}, 64'h1);
        got = SRAM_DQ;
        check("rd_data", got, exp);
        SRAM_CE_N = 1; SRAM_OE_N = 1;
        #1;
        check("rd_valid_release", {63'h0, rd_valid}, 64'h0);
        check_released("rd_bus_release");
        @(negedge clk);
        $display("txn RD addr=%05h data=%016h exp=%016h busy_cycles=%0d", a, got, exp, cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] got;
        int          cyc;
        bit          rdv;

        // Reset state, checked while reset is asserted.
        #2;
        check("reset_busy", {63'h0, busy}, 64'h0);
        check("reset_rd_valid", {63'h0, rd_valid}, 64'h0);
        check_released("reset_bus");
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
`ifdef SRAM_RESP_ERR_EN
        check("reset_addr_err", {63'h0, addr_err}, 64'h0);
`endif

        // Directed vectors: write/read pairs, lane masks, range limits.
        vecs.push_back('{1, 17'h00005, 64'hDEAD_BEEF_0123_4567, 0, 0, 64'h0});
        vecs.push_back('{0, 17'h00005, 64'h0, 1, 1, 64'hDEAD_BEEF_0123_4567});
        vecs.push_back('{1, 17'h00007, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0});
        vecs.push_back('{1, 17'h00007, 64'h0, 1, 0, 64'h0});
        vecs.push_back('{0, 17'h00007, 64'h0, 1, 1, 64'hFFFF_FFFF_0000_0000});
        vecs.push_back('{1, 17'h00007, 64'hAAAA_AAAA_5555_5555, 0, 1, 64'h0});
        vecs.push_back('{0, 17'h00007, 64'h0, 1, 1, 64'hAAAA_AAAA_0000_0000});
        vecs.push_back('{1, 17'h00000, 64'h0000_1234_5678_9ABC, 0, 0, 64'h0});
        vecs.push_back('{1, 17'h00400, 64'h1, 0, 0, 64'h0});
        vecs.push_back('{0, 17'h00400, 64'h0, 1, 1, 64'h0});
        vecs.push_back('{0, 17'h00000, 64'h0, 1, 1, 64'h0000_1234_5678_9ABC});
        vecs.push_back('{1, 17'h00009, 64'hCAFE_F00D_0BAD_C0DE, 0, 0, 64'h0});
        vecs.push_back('{1, 17'h00009, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h0});
        vecs.push_back('{0, 17'h00009, 64'h0, 1, 1, 64'hCAFE_F00D_0BAD_C0DE});
        vecs.push_back('{1, 17'h003FF, 64'h77, 0, 0, 64'h0});
        vecs.push_back('{1, 17'h013FF, 64'h99, 0, 0, 64'h0});
        vecs.push_back('{0, 17'h003FF, 64'h0, 1, 1, 64'h77});
        vecs.push_back('{0, 17'h1FFFF, 64'h0, 1, 1, 64'h0});
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].ub_n, vecs[i].lb_n);
            else            do_read(vecs[i].addr, vecs[i].exp, got);
        end

`ifdef SRAM_RESP_ERR_EN
        // Sticky error flag survives in-range traffic until err_clr.
        check("addr_err_set", {63'h0, addr_err}, 64'h1);
        do_read(17'h00005, 64'hDEAD_BEEF_0123_4567, got);
        check("addr_err_sticky", {63'h0, addr_err}, 64'h1);
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        check("addr_err_clear", {63'h0, addr_err}, 64'h0);
`endif

        // WE_N and OE_N low together: a write, bus never driven by the DUT.
        SRAM_ADDR = 17'h0000B; SRAM_CE_N = 0; SRAM_WE_N = 0; SRAM_OE_N = 0;
        SRAM_UB_N = 0; SRAM_LB_N = 0; tb_drv = 0;
        for (int k = 1; k <= ACCESS_CYCLES; k++) begin
            @(negedge clk);
            check("both_low_busy", {63'h0, busy}, 64'h1);
            check_released("both_low_bus_access");
        end
        tb_dq = 64'h0123_4567_89AB_CDEF; tb_drv = 1;
        @(negedge clk);
        check("both_low_hold_rd_valid", {63'h0, rd_valid}, 64'h0);
        tb_drv = 0;
        #1;
        check_released("both_low_bus_hold");
        SRAM_CE_N = 1; SRAM_WE_N = 1; SRAM_OE_N = 1; SRAM_UB_N = 1; SRAM_LB_N = 1;
        @(negedge clk);
        model_write(17'h0000B, 64'h0123_4567_89AB_CDEF, 0, 0);
        $display("txn WR+OE addr=0000b data=0123456789abcdef");
        do_read(17'h0000B, 64'h0123_4567_89AB_CDEF, got);

        // CE_N raised in the second ACCESS cycle: no commit.
        do_write(17'h0000D, 64'h1111_2222_3333_4444, 0, 0);
        SRAM_ADDR = 17'h0000D; SRAM_CE_N = 0; SRAM_WE_N = 0; SRAM_OE_N = 1;
        SRAM_UB_N = 0; SRAM_LB_N = 0; tb_dq = 64'h5555_6666_7777_8888; tb_drv = 1;
        @(negedge clk); @(negedge clk);
        SRAM_CE_N = 1; SRAM_WE_N = 1; tb_drv = 0;
        @(negedge clk);
        check("abort_busy", {63'h0, busy}, 64'h0);
        $display("txn WR-abort addr=0000d");
        @(negedge clk);
        do_read(17'h0000D, 64'h1111_2222_3333_4444, got);

        // Reset during a read HOLD releases the bus before any clock edge.
        SRAM_ADDR = 17'h00005; SRAM_CE_N = 0; SRAM_WE_N = 1; SRAM_OE_N = 0;
        run_access(cyc, rdv);
        check("rst_hold_rd_valid", {63'h0, rd_valid}, 64'h1);
        #2;
        rst = 1;
        #1;
        check("rst_async_rd_valid", {63'h0, rd_valid}, 64'h0);
        check_released("rst_async_bus");
        check("rst_async_busy", {63'h0, busy}, 64'h0);
        SRAM_CE_N = 1; SRAM_OE_N = 1;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        $display("txn RD-reset addr=00005");
        do_read(17'h00005, 64'hDEAD_BEEF_0123_4567, got);

        // Bus release and re-drive inside HOLD, then exit only on WE_N=OE_N=1.
        SRAM_ADDR = 17'h00005; SRAM_CE_N = 0; SRAM_WE_N = 1; SRAM_OE_N = 0;
        run_access(cyc, rdv);
        check("rel_first_data", SRAM_DQ, 64'hDEAD_BEEF_0123_4567);
        SRAM_WE_N = 0; SRAM_OE_N = 1;
        #1;
        check("rel_oe_high_rd_valid", {63'h0, rd_valid}, 64'h0);
        check_released("rel_oe_high_bus");
        @(negedge clk);
        SRAM_OE_N = 0; SRAM_WE_N = 1;
        #1;
        check("rel_redrive_rd_valid", {63'h0, rd_valid}, 64'h1);
        check("rel_redrive_data", SRAM_DQ, 64'hDEAD_BEEF_0123_4567);
        @(negedge clk);
        SRAM_OE_N = 1;
        @(negedge clk);
        SRAM_OE_N = 0;
        #1;
        check("rel_exit_idle", {63'h0, rd_valid}, 64'h0);
        run_access(cyc, rdv);
        check("rel_recapture_cycles", 64'(cyc), 64'(ACCESS_CYCLES));
        check("rel_recapture_data", SRAM_DQ, 64'hDEAD_BEEF_0123_4567);
        SRAM_CE_N = 1; SRAM_OE_N = 1;
        @(negedge clk);
        $display("txn RD-release addr=00005");

        // Randomized traffic against the memory model.
        for (int i = 0; i < 16; i++) do_write(17'(200 + i), {$urandom, $urandom}, 0, 0);
        for (int i = 0; i < 80; i++) begin
            logic [16:0] a;
            logic [63:0] d;
            bit          ub_n;
            bit          lb_n;
            if ($urandom_range(0, 9) < 2) a = 17'(MEM_DEPTH + $urandom_range(0, 131071 - MEM_DEPTH));
            else                          a = 17'(200 + $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                d = {$urandom, $urandom};
                ub_n = 1'($urandom_range(0, 1));
                lb_n = 1'($urandom_range(0, 1));
                do_write(a, d, ub_n, lb_n);
            end else begin
                do_read(a, model_read(a), got);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
